// File: rtl/ao486_wb_arbiter.sv
// Two-master to one-slave Wishbone B3 arbiter.
// Round-robin arbitration between m0 (CPU bridge) and m1 (secondary master).
// A grant is held for the whole bus cycle, so bursts are never split.
// A response watchdog aborts a granted cycle whose slave never answers.
//
// Handshake: a master requests by raising cyc. Once granted, its cyc/stb and
// transfer fields pass straight to the slave. A beat completes on any cycle
// where stb is high and the slave returns ack, err or rty. The master that is
// not granted sees no response and simply waits with cyc held.
// Dropping cyc ends ownership. One idle cycle always separates two grants.
module ao486_wb_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    // master 0
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    // master 1
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    // slave
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,
    // status
    output logic [1:0]      grant_o,
    output logic            timeout_o
);

    // Counter is kept at least one bit wide so a disabled watchdog still elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t        state, state_next;
    // last: master most recently served (0 = m0, 1 = m1). While in ABORT it
    // already names the aborted master, which is the master that must drop cyc.
    logic          last, last_next;
    logic [CW-1:0] count, count_next;

    logic          granted;
    logic          pick_m1;
    logic          g_cyc, g_stb;
    logic          resp;
    logic          expire;
    logic          owner_cyc;

    // Read data is broadcast; only the granted master sees a response.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // State, round-robin pointer and watchdog counter registers.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state <= IDLE;
            last  <= 1'b1;
            count <= '0;
        end else begin
            state <= state_next;
            last  <= last_next;
            count <= count_next;
        end
    end

    // Next-state, watchdog and bus routing decisions.
    always_comb begin
        state_next = state;
        last_next  = last;
        count_next = '0;
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_sel_o    = '0;
        s_we_o     = 1'b0;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_cti_o    = 3'b000;
        s_bte_o    = 2'b00;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_rty_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_rty_o   = 1'b0;
        grant_o    = 2'b00;
        timeout_o  = 1'b0;

        granted   = (state == GNT0) || (state == GNT1);
        pick_m1   = (state == GNT1);
        g_cyc     = pick_m1 ? m1_cyc_i : m0_cyc_i;
        g_stb     = pick_m1 ? m1_stb_i : m0_stb_i;
        resp      = s_ack_i | s_err_i | s_rty_i;
        owner_cyc = last ? m1_cyc_i : m0_cyc_i;
        // A slave response in the expiry cycle takes precedence over the abort.
        expire    = (TIMEOUT != 0) && granted && g_cyc && g_stb && !resp
                    && (count == LIMIT);

        if (granted) begin
            grant_o   = pick_m1 ? 2'b10 : 2'b01;
            s_adr_o   = pick_m1 ? m1_adr_i : m0_adr_i;
            s_dat_o   = pick_m1 ? m1_dat_i : m0_dat_i;
            s_sel_o   = pick_m1 ? m1_sel_i : m0_sel_i;
            s_we_o    = pick_m1 ? m1_we_i  : m0_we_i;
            s_cti_o   = pick_m1 ? m1_cti_i : m0_cti_i;
            s_bte_o   = pick_m1 ? m1_bte_i : m0_bte_i;
            s_cyc_o   = g_cyc & ~expire;
            s_stb_o   = g_stb & ~expire;
            timeout_o = expire;
            if (pick_m1) begin
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | expire;
                m1_rty_o = s_rty_i;
            end else begin
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | expire;
                m0_rty_o = s_rty_i;
            end
        end

        case (state)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last)) begin
                    state_next = GNT0;
                end else if (m1_cyc_i) begin
                    state_next = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!g_cyc) begin
                    state_next = IDLE;
                    last_next  = pick_m1;
                end else if (expire) begin
                    state_next = ABORT;
                    last_next  = pick_m1;
                end
            end
            ABORT: begin
                if (!owner_cyc) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Counter restarts on any response, idle strobe or change of state.
        if ((TIMEOUT != 0) && (state_next == state) && granted
            && g_cyc && g_stb && !resp) begin
            count_next = count + 1'b1;
        end
    end

endmodule
